// File: rtl/systolic_pkg.sv
// Shared types and constants for the output-stationary systolic MAC array.
// Optional SYSTOLIC_SAT_EN build macro selects saturating result output.
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN
  } state_t;

  localparam int FLUSH_BCAST = 1;

  function automatic int flush_sys(int n);
    return 2 * n - 1;
  endfunction

  function automatic int acc_width(int dw, int kmax);
    return 2 * dw + $clog2(kmax) + 1;
  endfunction

endpackage

// File: rtl/systolic_mac_array_if.sv
// Operand and result streams of the systolic MAC array.
// out_sat exists only when SYSTOLIC_SAT_EN is defined.
interface systolic_mac_array_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 24
);
  localparam int N  = ARRAY_SIZE;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_a;
  logic [N*DATA_WIDTH-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [RW-1:0]           out_row;
  logic [N*OUT_WIDTH-1:0]  out_data;
`ifdef SYSTOLIC_SAT_EN
  logic [N-1:0]            out_sat;
`endif

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_row, out_data
`ifdef SYSTOLIC_SAT_EN
    , input out_sat
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_row, out_data
`ifdef SYSTOLIC_SAT_EN
    , output out_sat
`endif
  );

endinterface

// File: rtl/systolic_pe.sv
// One MAC cell: exact accumulate, a/b forwarding regs, broadcast bypass.
// Build macro SYSTOLIC_SAT_EN does not affect this cell.
module systolic_pe #(
  parameter int DW = 8,
  parameter int AW = 23
) (
  input  logic                 clk,
  input  logic                 srstn,
  input  logic                 clear,
  input  logic                 bcast,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  input  logic signed [DW-1:0] a_bc,
  input  logic signed [DW-1:0] b_bc,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic signed [AW-1:0] acc
);

  logic signed [DW-1:0]   a_op;
  logic signed [DW-1:0]   b_op;
  logic signed [2*DW-1:0] prod;

  assign a_op = bcast ? a_bc : a_in;
  assign b_op = bcast ? b_bc : b_in;
  assign prod = a_op * b_op;

  always_ff @(posedge clk) begin
    if (!srstn || clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary NxN MAC array, systolic skew or broadcast feed.
// Define SYSTOLIC_SAT_EN for saturating outputs with out_sat flags.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int K_MAX      = 64,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                       clk,
  input  logic                       srstn,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] cfg_k,
  input  logic                       cfg_bcast,
  systolic_mac_array_if.slave        bus,
  output logic                       busy,
  output logic                       done
);

  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int AW = acc_width(DW, K_MAX);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(2 * N);
  localparam int EW = (AW > OW) ? AW : OW;

  state_t        state, state_nx;
  logic [KW-1:0] k_lat, k_lat_nx;
  logic [KW-1:0] k_cnt, k_cnt_nx;
  logic [FW-1:0] f_cnt, f_cnt_nx;
  logic [FW-1:0] f_last;
  logic [RW-1:0] row, row_nx;
  logic          bc_q, bc_nx;
  logic          clear;
  logic          fire;
  logic [KW-1:0] k_in;

  assign fire = bus.in_valid && bus.in_ready;
  assign busy = (state != S_IDLE);
  assign bus.out_row = row;

  always_comb begin
    k_in = cfg_k;
    if (cfg_k == '0) k_in = KW'(1);
    else if (cfg_k > KW'(K_MAX)) k_in = KW'(K_MAX);
  end

  assign f_last = bc_q ? FW'(FLUSH_BCAST - 1)
                       : FW'(flush_sys(N) - 1);

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state <= S_IDLE;
      k_lat <= '0;
      k_cnt <= '0;
      f_cnt <= '0;
      row   <= '0;
      bc_q  <= 1'b0;
    end else begin
      state <= state_nx;
      k_lat <= k_lat_nx;
      k_cnt <= k_cnt_nx;
      f_cnt <= f_cnt_nx;
      row   <= row_nx;
      bc_q  <= bc_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    k_lat_nx      = k_lat;
    k_cnt_nx      = k_cnt;
    f_cnt_nx      = f_cnt;
    row_nx        = row;
    bc_nx         = bc_q;
    clear         = 1'b0;
    done          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          k_lat_nx = k_in;
          bc_nx    = cfg_bcast;
          k_cnt_nx = '0;
          clear    = 1'b1;
          state_nx = S_FEED;
        end
      end
      S_FEED: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          k_cnt_nx = k_cnt + KW'(1);
          if (k_cnt + KW'(1) == k_lat) begin
            f_cnt_nx = '0;
            state_nx = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (f_cnt == f_last) begin
          row_nx   = '0;
          state_nx = S_DRAIN;
        end else begin
          f_cnt_nx = f_cnt + FW'(1);
        end
      end
      S_DRAIN: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (row == RW'(N - 1)) begin
            done     = 1'b1;
            state_nx = S_IDLE;
          end else begin
            row_nx = row + RW'(1);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Idle cycles feed zeros so bubbles never disturb the sums.
  logic signed [DW-1:0] a_src [N];
  logic signed [DW-1:0] b_src [N];
  logic signed [DW-1:0] a_row [N];
  logic signed [DW-1:0] b_col [N];
  logic signed [DW-1:0] a_bc  [N];
  logic signed [DW-1:0] b_bc  [N];

  for (genvar i = 0; i < N; i++) begin : g_src
    assign a_src[i] = fire ? bus.in_a[i*DW +: DW] : '0;
    assign b_src[i] = fire ? bus.in_b[i*DW +: DW] : '0;

    always_ff @(posedge clk) begin
      if (!srstn || clear) begin
        a_bc[i] <= '0;
        b_bc[i] <= '0;
      end else begin
        a_bc[i] <= a_src[i];
        b_bc[i] <= b_src[i];
      end
    end

    if (i == 0) begin : g_d0
      assign a_row[i] = a_src[i];
      assign b_col[i] = b_src[i];
    end else begin : g_dn
      logic signed [DW-1:0] sa [i];
      logic signed [DW-1:0] sb [i];
      always_ff @(posedge clk) begin
        if (!srstn || clear) begin
          for (int d = 0; d < i; d++) begin
            sa[d] <= '0;
            sb[d] <= '0;
          end
        end else begin
          sa[0] <= a_src[i];
          sb[0] <= b_src[i];
          for (int d = 1; d < i; d++) begin
            sa[d] <= sa[d-1];
            sb[d] <= sb[d-1];
          end
        end
      end
      assign a_row[i] = sa[i-1];
      assign b_col[i] = sb[i-1];
    end
  end

  logic signed [DW-1:0] a_h [N][N+1];
  logic signed [DW-1:0] b_v [N+1][N];
  logic signed [AW-1:0] acc [N][N];

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign a_h[i][0] = a_row[i];
    assign b_v[0][i] = b_col[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk   (clk),
        .srstn (srstn),
        .clear (clear),
        .bcast (bc_q),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_bc  (a_bc[i]),
        .b_bc  (b_bc[j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc[i][j])
      );
    end
  end

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [EW-1:0] MAXV =
    {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV =
    {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

  always_comb begin
    logic signed [EW-1:0] ext;
    bus.out_data = '0;
`ifdef SYSTOLIC_SAT_EN
    bus.out_sat  = '0;
`endif
    for (int j = 0; j < N; j++) begin
      ext = EW'(acc[row][j]);
`ifdef SYSTOLIC_SAT_EN
      if (ext > MAXV) begin
        bus.out_data[j*OW +: OW] = MAXV[OW-1:0];
        bus.out_sat[j] = 1'b1;
      end else if (ext < MINV) begin
        bus.out_data[j*OW +: OW] = MINV[OW-1:0];
        bus.out_sat[j] = 1'b1;
      end else begin
        bus.out_data[j*OW +: OW] = ext[OW-1:0];
      end
`else
      bus.out_data[j*OW +: OW] = ext[OW-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Randomized self-checking bench for systolic_mac_array.
// Honors SYSTOLIC_SAT_EN when computing expected outputs.
module tb_systolic_mac_array;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int KM = 64;
  localparam int OW = 16;
  localparam int KW = $clog2(KM + 1);

  logic          clk = 1'b0;
  logic          srstn = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] cfg_k = '0;
  logic          cfg_bcast = 1'b0;
  logic          busy;
  logic          done;

  systolic_mac_array_if #(
    .ARRAY_SIZE(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW)
  ) bus ();

  systolic_mac_array #(
    .ARRAY_SIZE(N), .DATA_WIDTH(DW),
    .K_MAX(KM), .OUT_WIDTH(OW)
  ) dut (
    .clk       (clk),
    .srstn     (srstn),
    .start     (start),
    .cfg_k     (cfg_k),
    .cfg_bcast (cfg_bcast),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag,
                          input logic [255:0] got,
                          input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // opa[k][i] = A[i][k], opb[k][j] = B[k][j]
  int opa [KM][N];
  int opb [KM][N];

  task automatic gen(input int mode, input int k);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        case (mode)
          1: begin
            opa[kk][i] = (i == kk) ? 1 : 0;
            opb[kk][i] = kk * 8 + i;
          end
          2: begin opa[kk][i] = 3;    opb[kk][i] = -5;   end
          3: begin opa[kk][i] = -128; opb[kk][i] = -128; end
          4: begin opa[kk][i] = 1;    opb[kk][i] = 1;    end
          default: begin
            opa[kk][i] = int'($urandom_range(0, 255)) - 128;
            opb[kk][i] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
  endtask

  task automatic exp_row(input int r, input int k,
                         output logic [N*OW-1:0] d,
                         output logic [N-1:0] s);
    int c;
    int v;
    int hi;
    int lo;
    hi = (1 << (OW - 1)) - 1;
    lo = -(1 << (OW - 1));
    d = '0;
    s = '0;
    for (int j = 0; j < N; j++) begin
      c = 0;
      for (int kk = 0; kk < k; kk++) c += opa[kk][r] * opb[kk][j];
      v = c;
`ifdef SYSTOLIC_SAT_EN
      if (c > hi) begin v = hi; s[j] = 1'b1; end
      if (c < lo) begin v = lo; s[j] = 1'b1; end
`endif
      d[j*OW +: OW] = v[OW-1:0];
    end
  endtask

  task automatic drive_beat(input int kk);
    int t;
    for (int i = 0; i < N; i++) begin
      t = opa[kk][i];
      bus.in_a[i*DW +: DW] = t[DW-1:0];
      t = opb[kk][i];
      bus.in_b[i*DW +: DW] = t[DW-1:0];
    end
  endtask

  task automatic check_row(input string tag, input int r,
                           input logic [N*OW-1:0] d,
                           input logic [N-1:0] s);
    check_eq({tag, "_valid"}, 256'(bus.out_valid), 256'(1));
    check_eq({tag, "_row"}, 256'(bus.out_row), 256'(r));
    check_eq({tag, "_data"}, 256'(bus.out_data), 256'(d));
`ifdef SYSTOLIC_SAT_EN
    check_eq({tag, "_sat"}, 256'(bus.out_sat), 256'(s));
`else
    if (s !== '0) check_eq({tag, "_nosat"}, 256'(s), 256'(0));
`endif
  endtask

  task automatic run_job(input int mode, input int cfgk,
                         input bit bc, input bit bubbles,
                         input int stall_row, input bit poke);
    int keff;
    int beat;
    int guard;
    int lat;
    int d0;
    bit tog;
    logic [N*OW-1:0] d;
    logic [N-1:0] s;
    keff = (cfgk == 0) ? 1 : ((cfgk > KM) ? KM : cfgk);
    gen(mode, keff);
    d0 = done_cnt;
    @(negedge clk);
    cfg_k = cfgk[KW-1:0];
    cfg_bcast = bc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_k = KW'($urandom);
    cfg_bcast = ~bc;
    check_eq("busy_feed", 256'(busy), 256'(1));
    beat = 0;
    guard = 0;
    tog = 1'b0;
    while (beat < keff && guard < 1000) begin
      guard++;
      if (bubbles && tog) begin
        bus.in_valid = 1'b0;
        bus.in_a = {$urandom, $urandom};
        bus.in_b = {$urandom, $urandom};
      end else begin
        bus.in_valid = 1'b1;
        drive_beat(beat);
      end
      tog = ~tog;
      #1;
      if (beat == 0 && bus.in_valid)
        check_eq("in_ready", 256'(bus.in_ready), 256'(1));
      @(negedge clk);
      if (bus.in_valid) beat++;
    end
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      start = poke && (lat == 0);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_eq("flush_lat", 256'(lat), 256'(bc ? 1 : 2 * N - 1));
    for (int r = 0; r < N; r++) begin
      exp_row(r, keff, d, s);
      if (r == stall_row) begin
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          #1;
          check_row("stall", r, d, s);
          check_eq("stall_done", 256'(done), 256'(0));
          @(negedge clk);
        end
      end
      bus.out_ready = 1'b1;
      start = poke && (r == 4 || r == N - 1);
      #1;
      check_row("row", r, d, s);
      check_eq("done", 256'(done), 256'(r == N - 1));
      @(negedge clk);
      start = 1'b0;
    end
    bus.out_ready = 1'b0;
    check_eq("busy_end", 256'(busy), 256'(0));
    check_eq("valid_end", 256'(bus.out_valid), 256'(0));
    repeat (2) @(negedge clk);
    check_eq("done_count", 256'(done_cnt - d0), 256'(1));
  endtask

  task automatic abort_job();
    gen(0, 10);
    @(negedge clk);
    cfg_k = KW'(10);
    cfg_bcast = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    for (int kk = 0; kk < 3; kk++) begin
      drive_beat(kk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    srstn = 1'b0;
    @(negedge clk);
    srstn = 1'b1;
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_valid", 256'(bus.out_valid), 256'(0));
    check_eq("rst_ready", 256'(bus.in_ready), 256'(0));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", 256'(busy), 256'(0));
    check_eq("reset_done", 256'(done), 256'(0));
    check_eq("reset_in_ready", 256'(bus.in_ready), 256'(0));
    check_eq("reset_out_valid", 256'(bus.out_valid), 256'(0));
    check_eq("reset_out_row", 256'(bus.out_row), 256'(0));
    srstn = 1'b1;
    @(negedge clk);

    run_job(1, 8, 1'b0, 1'b0, -1, 1'b0);
    run_job(1, 8, 1'b1, 1'b0, -1, 1'b0);
    run_job(2, 1, 1'b0, 1'b0, -1, 1'b0);
    run_job(2, 0, 1'b1, 1'b0, -1, 1'b0);
    run_job(3, 64, 1'b0, 1'b0, -1, 1'b0);
    run_job(3, 64, 1'b1, 1'b0, -1, 1'b0);
    run_job(0, 12, 1'b0, 1'b1, 2, 1'b0);
    run_job(0, 12, 1'b1, 1'b1, 2, 1'b0);
    abort_job();
    run_job(4, 4, 1'b0, 1'b0, -1, 1'b0);
    run_job(0, 20, 1'b0, 1'b0, -1, 1'b1);
    run_job(0, 5, 1'b1, 1'b0, -1, 1'b1);
    run_job(0, 100, 1'b0, 1'b0, -1, 1'b0);
    for (int t = 0; t < 4; t++)
      run_job(0, int'($urandom_range(0, 70)),
              1'($urandom), 1'($urandom),
              int'($urandom_range(0, N - 1)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
